// File: rtl/kv_icache.sv
// kv_icache: direct-mapped read-only instruction cache.
// Hits come from registered tag/data arrays; a miss fetches one full line.
module kv_icache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_flush,
  input  logic [ADDR_WIDTH-1:0]                i_cpu_addr,
  input  logic                                 i_cpu_valid,
  output logic                                 o_cpu_ready,
  output logic [DATA_WIDTH-1:0]                o_cpu_data,
  output logic                                 o_cpu_valid,
  input  logic                                 i_cpu_ready,
  output logic [ADDR_WIDTH-1:0]                o_mem_read_addr,
  output logic                                 o_mem_read_valid,
  input  logic                                 i_mem_read_ready,
  input  logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] i_mem_read_data,
  input  logic                                 i_mem_read_valid,
  output logic                                 o_mem_read_ready
);

  localparam int OFF   = $clog2(LINE_SIZE);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - OFF - IDX - 2;

  typedef logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] line_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-3:0] req_addr;
  logic [TAG_W-1:0]      req_tag;
  logic [IDX-1:0]        req_idx;
  logic [OFF-1:0]        req_off;
  logic [IDX-1:0]        cpu_idx;

  logic [NUM_LINES-1:0]  valid;
  logic [TAG_W-1:0]      tag_mem [NUM_LINES];
  line_t                 data_mem [NUM_LINES];
  logic [TAG_W-1:0]      rd_tag;
  line_t                 rd_line;
  logic                  rd_valid;
  logic                  no_alloc;

  logic accept;
  logic fill;
  logic hit;
  logic unused_lsb;

  assign req_tag = req_addr[ADDR_WIDTH-3:OFF+IDX];
  assign req_idx = req_addr[OFF+IDX-1:OFF];
  assign req_off = req_addr[OFF-1:0];
  assign cpu_idx = i_cpu_addr[OFF+IDX+1:OFF+2];

  assign unused_lsb = ^i_cpu_addr[1:0];

  assign accept = (state == S_IDLE) && i_cpu_valid;
  assign fill   = (state == S_WAIT) && i_mem_read_valid;
  // A flush landing on the lookup cycle must not be answered as a hit
  assign hit    = rd_valid && (rd_tag == req_tag) && !i_flush;

  always_ff @(posedge i_clk) begin
    if (fill) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= i_mem_read_data;
    end
    if (accept) begin
      rd_tag  <= tag_mem[cpu_idx];
      rd_line <= data_mem[cpu_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid           <= '0;
      rd_valid        <= 1'b0;
      no_alloc        <= 1'b0;
      req_addr        <= '0;
      o_cpu_data      <= '0;
      o_mem_read_addr <= '0;
    end else begin
      if (accept) begin
        req_addr <= i_cpu_addr[ADDR_WIDTH-1:2];
        rd_valid <= valid[cpu_idx] && !i_flush;
      end
      if (state == S_LOOKUP) begin
        no_alloc <= 1'b0;
        if (hit) begin
          o_cpu_data <= rd_line[req_off];
        end else begin
          o_mem_read_addr <= {req_tag, req_idx, {(OFF+2){1'b0}}};
        end
      end
      // A flush during the fill window keeps the arriving line unallocated
      if ((state == S_REQ || state == S_WAIT) && i_flush) begin
        no_alloc <= 1'b1;
      end
      if (fill) begin
        o_cpu_data <= i_mem_read_data[req_off];
      end
      if (i_flush) begin
        valid <= '0;
      end else if (fill && !no_alloc) begin
        valid[req_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    o_cpu_ready      = 1'b0;
    o_mem_read_valid = 1'b0;
    o_mem_read_ready = 1'b0;
    o_cpu_valid      = 1'b0;
    unique case (state)
      S_IDLE: begin
        o_cpu_ready = 1'b1;
        if (i_cpu_valid) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        state_nxt = hit ? S_RESP : S_REQ;
      end
      S_REQ: begin
        o_mem_read_valid = 1'b1;
        if (i_mem_read_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_mem_read_ready = 1'b1;
        if (i_mem_read_valid) state_nxt = S_RESP;
      end
      S_RESP: begin
        o_cpu_valid = 1'b1;
        if (i_cpu_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_kv_icache.sv
// tb_kv_icache: randomized and directed checks of kv_icache
// against a line-level cache model and a delay-programmable memory.
module tb_kv_icache;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [31:0]       cpu_addr;
  logic              cpu_valid;
  logic              cache_ready;
  logic [31:0]       resp_data;
  logic              resp_valid;
  logic              core_ready;
  logic [31:0]       mreq_addr;
  logic              mreq_valid;
  logic              mem_aready;
  logic [3:0][31:0]  line_data;
  logic              mem_dvalid;
  logic              mdata_ready;

  int total = 0;
  int bad   = 0;

  int          rdy_delay = 0;
  int          vld_delay = 0;
  int          req_cnt   = 0;
  logic [31:0] last_req  = '0;
  bit          addr_unstable = 1'b0;

  logic [31:0] model_line [int];

  kv_icache dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_flush          (flush),
    .i_cpu_addr       (cpu_addr),
    .i_cpu_valid      (cpu_valid),
    .o_cpu_ready      (cache_ready),
    .o_cpu_data       (resp_data),
    .o_cpu_valid      (resp_valid),
    .i_cpu_ready      (core_ready),
    .o_mem_read_addr  (mreq_addr),
    .o_mem_read_valid (mreq_valid),
    .i_mem_read_ready (mem_aready),
    .i_mem_read_data  (line_data),
    .i_mem_read_valid (mem_dvalid),
    .o_mem_read_ready (mdata_ready)
  );

  always #5 clk = ~clk;

  // Line memory: word k of a line is line_addr + 4k.
  initial begin : mem_proc
    int mst;
    int mcnt;
    logic [31:0] seen;
    mst = 0;
    mcnt = 0;
    seen = '0;
    mem_aready = 1'b0;
    mem_dvalid = 1'b0;
    line_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mem_aready = 1'b0;
        mem_dvalid = 1'b0;
        mst = 0;
        mcnt = 0;
      end else begin
        case (mst)
          0: if (mreq_valid) begin
            seen = mreq_addr;
            mcnt = 0;
            mst = 1;
            mem_aready = (rdy_delay == 0);
          end
          1: if (mem_aready) begin
            mem_aready = 1'b0;
            req_cnt++;
            last_req = seen;
            mcnt = 0;
            for (int k = 0; k < 4; k++) line_data[k] = seen + 32'(4 * k);
            mst = 2;
            if (vld_delay == 0) begin
              mem_dvalid = 1'b1;
              mst = 3;
            end
          end else begin
            if (!mreq_valid || mreq_addr !== seen) addr_unstable = 1'b1;
            mcnt++;
            if (mcnt >= rdy_delay) mem_aready = 1'b1;
          end
          2: begin
            mcnt++;
            if (mcnt >= vld_delay) begin
              mem_dvalid = 1'b1;
              mst = 3;
            end
          end
          default: begin
            mem_dvalid = 1'b0;
            mst = 0;
          end
        endcase
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    flush = 1'b0;
    cpu_valid = 1'b0;
    cpu_addr = '0;
    core_ready = 1'b0;
    rdy_delay = 0;
    vld_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_line.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_line.delete();
  endtask

  task automatic fetch(input logic [31:0] a, input int hold,
                       output logic [31:0] d, output int lat,
                       output bit stable);
    int n;
    d = '0;
    lat = 0;
    stable = 1'b1;
    cpu_addr = a;
    cpu_valid = 1'b1;
    n = 0;
    while (!cache_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (!resp_valid) begin
      bad++;
      $display("FAIL fetch_timeout addr=%h got=no_response want=response", a);
    end else begin
      d = resp_data;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (!resp_valid || resp_data !== d) stable = 1'b0;
      end
      core_ready = 1'b1;
      @(posedge clk);
      #1;
      core_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (cache_ready !== 1'b1) begin
      bad++; $display("FAIL rst_cpu_ready got=%b want=1", cache_ready);
    end
    total++;
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_cpu_valid got=%b want=0", resp_valid);
    end
    total++;
    if (mreq_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mem_valid got=%b want=0", mreq_valid);
    end
    total++;
    if (mdata_ready !== 1'b0) begin
      bad++; $display("FAIL rst_mem_ready got=%b want=0", mdata_ready);
    end
    total++;
    if (resp_data !== 32'h0) begin
      bad++; $display("FAIL rst_cpu_data got=%h want=0", resp_data);
    end
    total++;
    if (mreq_addr !== 32'h0) begin
      bad++; $display("FAIL rst_mem_addr got=%h want=0", mreq_addr);
    end
  endtask

  task automatic test_cold_miss();
    logic [31:0] d;
    int lat, r0;
    bit st;
    r0 = req_cnt;
    fetch(32'h0000_0108, 0, d, lat, st);
    total++;
    if (last_req !== 32'h0000_0100) begin
      bad++; $display("FAIL cold_req_addr got=%h want=%h", last_req, 32'h100);
    end
    total++;
    if (d !== 32'h0000_0108) begin
      bad++; $display("FAIL cold_data got=%h want=%h", d, 32'h108);
    end
    total++;
    if (req_cnt - r0 != 1) begin
      bad++; $display("FAIL cold_req_count got=%0d want=1", req_cnt - r0);
    end
    total++;
    if (lat != 4) begin
      bad++; $display("FAIL cold_latency got=%0d want=4", lat);
    end
  endtask

  task automatic test_hit();
    logic [31:0] d;
    int lat, r0;
    bit st;
    r0 = req_cnt;
    fetch(32'h0000_010C, 0, d, lat, st);
    total++;
    if (d !== 32'h0000_010C) begin
      bad++; $display("FAIL hit_data got=%h want=%h", d, 32'h10C);
    end
    total++;
    if (lat != 2) begin
      bad++; $display("FAIL hit_latency got=%0d want=2", lat);
    end
    total++;
    if (req_cnt != r0) begin
      bad++; $display("FAIL hit_req_count got=%0d want=0", req_cnt - r0);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] seq [3];
    logic [31:0] d;
    int lat, r0;
    bit st;
    seq = '{32'h0000_0100, 32'h0000_1100, 32'h0000_0100};
    apply_reset();
    r0 = req_cnt;
    for (int i = 0; i < 3; i++) begin
      fetch(seq[i], 0, d, lat, st);
      total++;
      if (d !== seq[i]) begin
        bad++; $display("FAIL conflict_data%0d got=%h want=%h", i, d, seq[i]);
      end
      total++;
      if (last_req !== seq[i]) begin
        bad++; $display("FAIL conflict_req%0d got=%h want=%h", i, last_req, seq[i]);
      end
    end
    total++;
    if (req_cnt - r0 != 3) begin
      bad++; $display("FAIL conflict_req_count got=%0d want=3", req_cnt - r0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    int lat, r0;
    bit st;
    apply_reset();
    addr_unstable = 1'b0;
    rdy_delay = 5;
    vld_delay = 7;
    r0 = req_cnt;
    fetch(32'h0000_0340, 4, d, lat, st);
    rdy_delay = 0;
    vld_delay = 0;
    total++;
    if (addr_unstable) begin
      bad++; $display("FAIL bp_addr_stable got=unstable want=stable");
    end
    total++;
    if (lat != 16) begin
      bad++; $display("FAIL bp_latency got=%0d want=16", lat);
    end
    total++;
    if (d !== 32'h0000_0340) begin
      bad++; $display("FAIL bp_data got=%h want=%h", d, 32'h340);
    end
    total++;
    if (!st) begin
      bad++; $display("FAIL bp_resp_stable got=changed want=held");
    end
    total++;
    if (req_cnt - r0 != 1) begin
      bad++; $display("FAIL bp_req_count got=%0d want=1", req_cnt - r0);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int lat, r0;
    bit st, seen_wait;
    apply_reset();
    fetch(32'h0000_0200, 0, d, lat, st);
    pulse_flush();
    r0 = req_cnt;
    fetch(32'h0000_0204, 0, d, lat, st);
    total++;
    if (req_cnt - r0 != 1 || d !== 32'h0000_0204) begin
      bad++; $display("FAIL flush_idle got=req%0d/%h want=req1/%h", req_cnt - r0, d, 32'h204);
    end
    vld_delay = 3;
    seen_wait = 1'b0;
    r0 = req_cnt;
    fork
      fetch(32'h0000_0600, 0, d, lat, st);
      begin
        for (int i = 0; i < 50 && !mdata_ready; i++) begin
          @(posedge clk);
          #1;
        end
        if (mdata_ready) begin
          seen_wait = 1'b1;
          pulse_flush();
        end
      end
    join
    vld_delay = 0;
    total++;
    if (!seen_wait) begin
      bad++; $display("FAIL flush_wait_reach got=no_wait want=wait");
    end
    total++;
    if (d !== 32'h0000_0600) begin
      bad++; $display("FAIL flush_wait_data got=%h want=%h", d, 32'h600);
    end
    fetch(32'h0000_0600, 0, d, lat, st);
    total++;
    if (req_cnt - r0 != 2) begin
      bad++; $display("FAIL flush_wait_refetch got=req%0d want=req2", req_cnt - r0);
    end
    r0 = req_cnt;
    fork
      fetch(32'h0000_0604, 0, d, lat, st);
      begin
        @(posedge clk);
        #1;
        pulse_flush();
      end
    join
    total++;
    if (req_cnt - r0 != 1 || d !== 32'h0000_0604) begin
      bad++; $display("FAIL flush_lookup got=req%0d/%h want=req1/%h", req_cnt - r0, d, 32'h604);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] d;
    int lat, r0;
    bit st;
    apply_reset();
    vld_delay = 10;
    cpu_addr = 32'h0000_0700;
    cpu_valid = 1'b1;
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    for (int i = 0; i < 50 && !mdata_ready; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (!mdata_ready) begin
      bad++; $display("FAIL rmid_reach_wait got=0 want=1");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (mdata_ready !== 1'b0 || cache_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_outputs got=mrdy%b/crdy%b want=mrdy0/crdy1", mdata_ready, cache_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    vld_delay = 0;
    model_line.delete();
    @(posedge clk);
    #1;
    r0 = req_cnt;
    fetch(32'h0000_0700, 0, d, lat, st);
    total++;
    if (req_cnt - r0 != 1 || d !== 32'h0000_0700) begin
      bad++; $display("FAIL rmid_refetch got=req%0d/%h want=req1/%h", req_cnt - r0, d, 32'h700);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    int lat, r0;
    bit st;
    apply_reset();
    r0 = req_cnt;
    fetch(32'hFFFF_FFFF, 0, d, lat, st);
    total++;
    if (last_req !== 32'hFFFF_FFF0 || d !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_miss got=%h/%h want=%h/%h", last_req, d, 32'hFFFF_FFF0, 32'hFFFF_FFFC);
    end
    fetch(32'hFFFF_FFF1, 0, d, lat, st);
    total++;
    if (req_cnt - r0 != 1 || d !== 32'hFFFF_FFF0) begin
      bad++; $display("FAIL wrap_hit got=req%0d/%h want=req1/%h", req_cnt - r0, d, 32'hFFFF_FFF0);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, line, expd;
    logic [23:0] tg;
    int lat, r0, key, hold, exp_lat;
    bit st, exp_hit;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: tg = 24'h000000;
        1: tg = 24'h000001;
        2: tg = 24'h000011;
        default: tg = 24'hFFFFFF;
      endcase
      a = {tg, 8'h00} + ($urandom & 32'hFF);
      expd = a & ~32'h3;
      line = a & ~32'hF;
      key = int'((a >> 4) % 16);
      exp_hit = model_line.exists(key) && model_line[key] == line;
      rdy_delay = $urandom_range(0, 2);
      vld_delay = $urandom_range(0, 2);
      hold = $urandom_range(0, 2);
      exp_lat = exp_hit ? 2 : 4 + rdy_delay + vld_delay;
      r0 = req_cnt;
      fetch(a, hold, d, lat, st);
      total++;
      if (d !== expd) begin
        bad++; $display("FAIL rnd%0d_data addr=%h got=%h want=%h", i, a, d, expd);
      end
      total++;
      if (lat != exp_lat || !st) begin
        bad++; $display("FAIL rnd%0d_timing addr=%h got=lat%0d/st%b want=lat%0d/st1", i, a, lat, st, exp_lat);
      end
      total++;
      if (req_cnt - r0 != (exp_hit ? 0 : 1)) begin
        bad++; $display("FAIL rnd%0d_reqs addr=%h got=%0d want=%0d", i, a, req_cnt - r0, exp_hit ? 0 : 1);
      end
      if (!exp_hit) begin
        total++;
        if (last_req !== line) begin
          bad++; $display("FAIL rnd%0d_req_addr got=%h want=%h", i, last_req, line);
        end
        model_line[key] = line;
      end
      if ($urandom_range(0, 9) == 0) pulse_flush();
    end
    rdy_delay = 0;
    vld_delay = 0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cpu_addr = '0;
    cpu_valid = 1'b0;
    core_ready = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_backpressure();
    test_flush();
    test_reset_mid_miss();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kv_icache.md
# kv_icache

Direct-mapped, read-only instruction cache between the fetch stage and the line-read memory port. It accepts one word-fetch request at a time from the core and answers hits from an internal tag/data array. On a miss it acts as the initiator on the line-read interface: it issues the line address, receives a full LINE_SIZE-word line, allocates it, and returns the requested word. It is the requester counterpart of the behavioral line memory used in simulation.

## Interface
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 32, byte address width.
- LINE_SIZE, 4, words per line (power of two, ≥2).
- NUM_LINES, 16, cache lines (power of two, ≥2).
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_flush  in  1  invalidate all lines.
- i_cpu_addr  in  ADDR_WIDTH  fetch byte address (bits [1:0] ignored).
- i_cpu_valid  in  1  fetch request valid.
- o_cpu_ready  out  1  fetch request accepted when high with i_cpu_valid.
- o_cpu_data  out  DATA_WIDTH  fetched word.
- o_cpu_valid  out  1  o_cpu_data valid.
- i_cpu_ready  in  1  core accepts the response.
- o_mem_read_addr  out  ADDR_WIDTH  line-aligned read address.
- o_mem_read_valid  out  1  read address valid.
- i_mem_read_ready  in  1  memory accepts the address.
- i_mem_read_data  in  DATA_WIDTH × [LINE_SIZE-1:0]  returned line; element k is word k.
- i_mem_read_valid  in  1  line data valid.
- o_mem_read_ready  out  1  cache accepts the line.

## Operation
- Address split: OFF = log2(LINE_SIZE), IDX = log2(NUM_LINES). Word offset = addr[OFF+1:2]; index = addr[OFF+IDX+1:OFF+2]; tag = addr[ADDR_WIDTH-1:OFF+IDX+2].
- Storage: per line, a valid bit, a tag, and LINE_SIZE words. The data and tag arrays are read synchronously (one-cycle registered read).
- FSM states:
  - IDLE: o_cpu_ready=1. On i_cpu_valid, latch the address, start the array read, and go to LOOKUP.
  - LOOKUP: if valid and tag match (hit), load o_cpu_data with the selected word and go to RESP. On a miss, drive o_mem_read_addr = {tag, index, OFF+2 zeros} and go to REQ.
  - REQ: o_mem_read_valid=1 with the address held stable. On i_mem_read_ready, go to WAIT.
  - WAIT: o_mem_read_ready=1. On i_mem_read_valid, write the whole line and the tag, set valid (unless suppressed, see flush), load o_cpu_data = i_mem_read_data[offset], and go to RESP.
  - RESP: o_cpu_valid=1, with o_cpu_data held. On i_cpu_ready, go to IDLE.
- o_cpu_ready, o_mem_read_valid, o_mem_read_ready and o_cpu_valid are decoded from state only, with no combinational path from inputs.
- Only one request is outstanding; there is no hit-under-miss.

## Timing
- Reset: state=IDLE and all valid bits=0. o_cpu_valid=0, o_mem_read_valid=0, o_mem_read_ready=0, o_cpu_data=0, o_mem_read_addr=0. o_cpu_ready=1 in the first cycle after reset is released.
- Reset mid-operation: returns to IDLE immediately and drops any pending memory handshake. The bench memory must also be reset.
- Hit latency: request handshake in cycle N, o_cpu_valid high in cycle N+2.
- Miss: o_mem_read_valid rises in cycle N+2. o_cpu_valid rises one cycle after the i_mem_read_valid handshake.
- RESP holds o_cpu_valid and o_cpu_data stable indefinitely while i_cpu_ready=0.
- The next request can be accepted the cycle after the response handshake, so the hit throughput is one word per 3 cycles.
- i_flush, sampled in any state:
  - It clears every valid bit at that edge.
  - If it is seen in REQ or WAIT, or in the same cycle as the fill, the fill still completes and the word is returned, but the line is not marked valid.
  - A flush coinciding with a lookup in LOOKUP forces a miss.
- Two addresses with the same index and different tags evict each other; the latest fill wins.
- Wrap-around: the top line address (all ones) fetches normally, and o_mem_read_addr is aligned, never incremented.

## Test plan
- Cold miss: after reset, fetch 0x0000_0108. The memory model returns word k = line_addr + 4k. Required: o_mem_read_addr=0x0000_0100 and o_cpu_data=0x0000_0108, with exactly one memory request.
- Hit: after the above, fetch 0x0000_010C. Required: o_cpu_data=0x0000_010C two cycles after the handshake, and o_mem_read_valid stays 0.
- Conflict eviction: fetch 0x0000_0100, then 0x0000_1100 (same index 0, NUM_LINES=16), then 0x0000_0100. Required: three memory requests, each returning its address.
- Backpressure: memory holds i_mem_read_ready=0 for 5 cycles and i_mem_read_valid low for 7 cycles, and the core holds i_cpu_ready=0 for 4 cycles in RESP. Required: o_mem_read_addr, o_cpu_valid and o_cpu_data stay stable, and there is no duplicate request.
- Flush: fill 0x0000_0200, pulse i_flush in IDLE, then fetch 0x0000_0204. Required: a new memory request. Repeat with i_flush pulsed in WAIT: the word is still returned, and an immediate refetch misses.
- Reset mid-miss: assert i_rst while in WAIT. Required: the next cycle shows o_mem_read_ready=0 and o_cpu_ready=1, and a subsequent fetch of the same address misses.
